pmod_adc_block: RTL and testbench
=================================

# pmod_adc_block

Serial-read controller for a dual-channel Pmod ADC (AD7476-class, 12-bit, two data lines sharing one chip select and serial clock). It is the receive-side counterpart of the Pmod DAC path. On a one-cycle `start` it runs one SPI frame: it asserts chip select, generates a divided serial clock, shifts in both data lines and presents the two samples to the SoC with a one-cycle valid strobe.

## Interface
Parameters:
- `RESOLUTION`, 12: sample width per channel. Must be ≤ `FRAME_BITS`.
- `FRAME_BITS`, 16: serial clock periods per frame. Leading zeros are followed by `RESOLUTION` data bits.
- `CLK_DIV`, 2: half-period of `adc_sclk`, in `clk` cycles. Must be ≥1.
- `QUIET_CYCLES`, 4: minimum `adc_cs_n` high time after a frame, in `clk` cycles. Must be ≥1.

Ports:
- `clk` input 1: system clock. Everything is on its rising edge.
- `rst` input 1: reset, synchronous and active-low. Sampled only on rising `clk`.
- `start` input 1: request one conversion. Accepted only in IDLE.
- `dout0` output RESOLUTION: last complete channel-0 sample.
- `dout1` output RESOLUTION: last complete channel-1 sample.
- `dout_valid` output 1: one-cycle pulse when `dout0` and `dout1` update.
- `busy` output 1: high from acceptance of `start` through the end of QUIET.
- `adc_cs_n` output 1: ADC chip select, active low.
- `adc_sclk` output 1: serial clock. Idles high (CPOL=1).
- `adc_d0` input 1: ADC channel-0 serial data.
- `adc_d1` input 1: ADC channel-1 serial data.

## Operation
- All outputs are registered. No output is combinational from an input.
- Reset (`rst`=0 at an edge) forces the following, and takes priority over everything:
  - state IDLE, counters 0, shift registers 0.
  - `adc_cs_n`=1, `adc_sclk`=1, `busy`=0, `dout_valid`=0, `dout0`=`dout1`=0.
- States:
  - IDLE: `adc_cs_n`=1, `adc_sclk`=1, `busy`=0. If `start`=1, go to CS_SETUP and clear both shift registers.
  - CS_SETUP: `adc_cs_n`=0, `adc_sclk`=1, `busy`=1. Stay `CLK_DIV` cycles, then go to SHIFT.
  - SHIFT: `adc_cs_n`=0. Each bit period is `CLK_DIV` cycles with `adc_sclk` low, then `CLK_DIV` cycles high. There are `FRAME_BITS` bit periods.
    - On the `clk` edge that drives `adc_sclk` from 0 to 1, shift `adc_d0` and `adc_d1` into their registers at the LSB end. The stream is MSB first.
    - At the end of the last high phase, go to QUIET.
  - QUIET: `adc_cs_n`=1, `adc_sclk`=1, `busy`=1. Stay `QUIET_CYCLES` cycles, then go to IDLE.
- On entry to QUIET:
  - `dout0` ← low `RESOLUTION` bits of the channel-0 shift register; `dout1` likewise for channel 1.
  - `dout_valid`=1 for exactly that one cycle.
  - Leading (`FRAME_BITS`−`RESOLUTION`) bits are discarded whatever their value.
- `start` outside IDLE is ignored. It is not queued.
- If `start` is held high, a new frame begins on the first IDLE cycle. The minimum frame-to-frame spacing is therefore busy time + 1 cycle.
- `dout0`/`dout1` hold their value between frames. They are never partially updated.
- Bit counter width is $clog2(FRAME_BITS+1). Divider counter width is $clog2(CLK_DIV+1). Neither counter wraps mid-frame.

## Timing
- Let H=`CLK_DIV` and F=`FRAME_BITS`. Take edge E0 as the edge where `start`=1 is sampled in IDLE.
- After E0: `busy`=1 and `adc_cs_n`=0. There is no combinational `start`→`busy` path.
- First `adc_sclk` falling transition: after edge E0+H.
- Sample k (k=1..F) is taken on edge E0+H+(2k−1)·H.
- `dout_valid`=1 and new `dout*` values appear after edge E0+H+2H·F. At the same edge `adc_cs_n`=1.
- `busy`=0 after edge E0+H+2H·F+QUIET_CYCLES.
- Defaults (H=2, F=16, Q=4): samples on E0+4, +8, …, +64. Valid after E0+66. IDLE after E0+70.
- Reset mid-frame: outputs take reset values at that edge. No `dout_valid` pulse. Previous `dout*` are cleared to 0.
- Reset and `start` on the same edge: reset wins and the frame does not start.

## Test plan
- Basic frame, defaults: the ADC model drives `adc_d0`=0x0A5C and `adc_d1`=0x03F1 as 4 zeros plus 12 bits MSB first, changing on `adc_sclk` falls.
  - `dout0`=0xA5C and `dout1`=0x3F1.
  - `dout_valid` is a single pulse after E0+66; `busy` falls after E0+70.
  - Exactly 16 `adc_sclk` rising edges occur while `adc_cs_n`=0.
- Leading bits nonzero: the model sends 0xF123 on both lines. `dout0`=`dout1`=0x123.
- `start` pulsed at E0+10 and E0+69: no second frame. `adc_cs_n` stays high from E0+66 until the next accepted `start`.
- `start` held high continuously: frames begin 71 cycles apart with `dout_valid` every 71 cycles, and `adc_cs_n` high ≥4 cycles between frames.
- `rst`=0 at E0+30: after that edge `adc_cs_n`=1, `adc_sclk`=1, `busy`=0, `dout*`=0, no `dout_valid`. A fresh `start` then yields a correct frame.
- CLK_DIV=1, FRAME_BITS=12, RESOLUTION=12, sample 0xFFF then 0x000: values are correct and valid appears after E0+25.

Source files
------------

// File: rtl/pmod_adc_block.sv
// Serial-read controller for a dual-channel 12-bit Pmod ADC: one start pulse runs one SPI
// frame (CPOL=1) and returns both channel samples with a single-cycle valid strobe.
module pmod_adc_block #(
  parameter int RESOLUTION   = 12,
  parameter int FRAME_BITS   = 16,
  parameter int CLK_DIV      = 2,
  parameter int QUIET_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [RESOLUTION-1:0] dout0,
  output logic [RESOLUTION-1:0] dout1,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  input  logic                  adc_d0,
  input  logic                  adc_d1
);

  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int Q_W   = $clog2(QUIET_CYCLES + 1);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(QUIET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, QUIET} state_t;

  state_t                state, state_n;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
  logic [DIV_W-1:0]      div_cnt, div_cnt_n;
  logic [Q_W-1:0]        q_cnt, q_cnt_n;
  logic [RESOLUTION-1:0] sh0, sh0_n, sh1, sh1_n;
  logic [RESOLUTION-1:0] dout0_n, dout1_n;
  logic                  valid_n, busy_n, cs_n_n, sclk_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      q_cnt      <= '0;
      sh0        <= '0;
      sh1        <= '0;
      dout0      <= '0;
      dout1      <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      adc_cs_n   <= 1'b1;
      adc_sclk   <= 1'b1;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      div_cnt    <= div_cnt_n;
      q_cnt      <= q_cnt_n;
      sh0        <= sh0_n;
      sh1        <= sh1_n;
      dout0      <= dout0_n;
      dout1      <= dout1_n;
      dout_valid <= valid_n;
      busy       <= busy_n;
      adc_cs_n   <= cs_n_n;
      adc_sclk   <= sclk_n;
    end
  end

  // Next values for every register, so each output comes straight from a flop.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
    q_cnt_n   = q_cnt;
    sh0_n     = sh0;
    sh1_n     = sh1;
    dout0_n   = dout0;
    dout1_n   = dout1;
    valid_n   = 1'b0;
    busy_n    = busy;
    cs_n_n    = adc_cs_n;
    sclk_n    = adc_sclk;

    case (state)
      IDLE: begin
        if (start) begin
          state_n   = CS_SETUP;
          busy_n    = 1'b1;
          cs_n_n    = 1'b0;
          sclk_n    = 1'b1;
          div_cnt_n = '0;
          bit_cnt_n = '0;
          sh0_n     = '0;
          sh1_n     = '0;
        end
      end
      CS_SETUP: begin
        if (div_cnt == DIV_LAST) begin
          state_n   = SHIFT;
          div_cnt_n = '0;
          sclk_n    = 1'b0;
        end else begin
          div_cnt_n = div_cnt + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = '0;
          if (!adc_sclk) begin
            // Leading frame bits simply fall off the top of the register.
            sclk_n = 1'b1;
            sh0_n  = (sh0 << 1) | RESOLUTION'(adc_d0);
            sh1_n  = (sh1 << 1) | RESOLUTION'(adc_d1);
          end else if (bit_cnt == BIT_LAST) begin
            state_n   = QUIET;
            bit_cnt_n = bit_cnt + BIT_W'(1);
            q_cnt_n   = '0;
            cs_n_n    = 1'b1;
            dout0_n   = sh0;
            dout1_n   = sh1;
            valid_n   = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
            sclk_n    = 1'b0;
          end
        end else begin
          div_cnt_n = div_cnt + DIV_W'(1);
        end
      end
      QUIET: begin
        if (q_cnt == Q_LAST) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          q_cnt_n = q_cnt + Q_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pmod_adc_block.sv
// Self-checking bench: default-parameter instance plus a CLK_DIV=1, 12-bit-frame instance,
// each fed by a behavioural ADC that shifts its word out MSB first on adc_sclk falls.
module tb_pmod_adc_block;

  localparam int H = 2, F = 16, R = 12, Q = 4;
  localparam int T_VALID = H + 2 * H * F;
  localparam int T_IDLE  = T_VALID + Q;
  localparam int H2 = 1, F2 = 12, R2 = 12, Q2 = 4;
  localparam int T2_VALID = H2 + 2 * H2 * F2;
  localparam int T2_IDLE  = T2_VALID + Q2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b;
  logic [R-1:0]  dout0_a, dout1_a;
  logic [R2-1:0] dout0_b, dout1_b;
  logic valid_a, busy_a, cs_n_a, sclk_a, adc_d0_a, adc_d1_a;
  logic valid_b, busy_b, cs_n_b, sclk_b, adc_d0_b, adc_d1_b;

  pmod_adc_block dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .dout0(dout0_a), .dout1(dout1_a), .dout_valid(valid_a), .busy(busy_a),
    .adc_cs_n(cs_n_a), .adc_sclk(sclk_a), .adc_d0(adc_d0_a), .adc_d1(adc_d1_a)
  );

  pmod_adc_block #(.RESOLUTION(R2), .FRAME_BITS(F2), .CLK_DIV(H2), .QUIET_CYCLES(Q2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .dout0(dout0_b), .dout1(dout1_b), .dout_valid(valid_b), .busy(busy_b),
    .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .adc_d0(adc_d0_b), .adc_d1(adc_d1_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  // ADC models: chip-select fall rewinds the word, each sclk fall presents the next bit.
  logic [F-1:0]  tx0_a = '0, tx1_a = '0;
  logic [F2-1:0] tx0_b = '0, tx1_b = '0;
  int idx_a = 0, idx_b = 0;
  initial begin adc_d0_a = 1'b0; adc_d1_a = 1'b0; adc_d0_b = 1'b0; adc_d1_b = 1'b0; end

  always @(negedge cs_n_a, negedge sclk_a) begin
    if (!cs_n_a && sclk_a) idx_a = F;
    else if (!cs_n_a && !sclk_a && idx_a > 0) begin
      idx_a = idx_a - 1;
      adc_d0_a = tx0_a[idx_a];
      adc_d1_a = tx1_a[idx_a];
    end
  end

  always @(negedge cs_n_b, negedge sclk_b) begin
    if (!cs_n_b && sclk_b) idx_b = F2;
    else if (!cs_n_b && !sclk_b && idx_b > 0) begin
      idx_b = idx_b - 1;
      adc_d0_b = tx0_b[idx_b];
      adc_d1_b = tx1_b[idx_b];
    end
  end

  // Frame bookkeeping observed on the pins.
  int rises_a = 0, valid_cnt_a = 0, last_valid_a = 0, prev_valid_a = 0;
  int cs_run_a = 0, last_run_a = 0, valid_cnt_b = 0;
  always @(posedge sclk_a) if (!cs_n_a) rises_a++;
  always @(negedge clk) begin
    if (valid_a) begin
      valid_cnt_a++;
      prev_valid_a = last_valid_a;
      last_valid_a = cyc;
    end
    if (valid_b) valid_cnt_b++;
    if (cs_n_a) cs_run_a++;
    else begin
      if (cs_run_a > 0) last_run_a = cs_run_a;
      cs_run_a = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d, required < 20000)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Pulses start_a across one edge; returns the cycle number of that edge (E0).
  task automatic pulseStartA(output int e0);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    e0 = cyc;
  endtask

  task automatic applyStimulus(input logic [F-1:0] w0, input logic [F-1:0] w1, input bit extra);
    int e0, v0, r0;
    tx0_a = w0;
    tx1_a = w1;
    v0 = valid_cnt_a;
    r0 = rises_a;
    pulseStartA(e0);
    checkOutput("busy_after_start", 32'(busy_a), 32'd1);
    checkOutput("cs_low_after_start", 32'(cs_n_a), 32'd0);
    if (extra) begin
      waitUntil(e0 + 9);  start_a = 1'b1;
      waitUntil(e0 + 10); start_a = 1'b0;
    end
    waitUntil(e0 + T_VALID - 1);
    checkOutput("valid_early", 32'(valid_a), 32'd0);
    checkOutput("cs_held_low", 32'(cs_n_a), 32'd0);
    waitUntil(e0 + T_VALID);
    checkOutput("valid_pulse", 32'(valid_a), 32'd1);
    checkOutput("cs_released", 32'(cs_n_a), 32'd1);
    checkOutput("dout0", 32'(dout0_a), 32'(w0[R-1:0]));
    checkOutput("dout1", 32'(dout1_a), 32'(w1[R-1:0]));
    if (extra) begin
      waitUntil(e0 + 68); start_a = 1'b1;
    end
    waitUntil(e0 + T_IDLE - 1);
    start_a = 1'b0;
    checkOutput("busy_in_quiet", 32'(busy_a), 32'd1);
    waitUntil(e0 + T_IDLE);
    checkOutput("busy_done", 32'(busy_a), 32'd0);
    checkOutput("valid_count", 32'(valid_cnt_a - v0), 32'd1);
    checkOutput("sclk_rises", 32'(rises_a - r0), 32'(F));
    if (extra) begin
      waitUntil(e0 + T_IDLE + 12);
      checkOutput("ignored_start_cs", 32'(cs_n_a), 32'd1);
      checkOutput("ignored_start_busy", 32'(busy_a), 32'd0);
      checkOutput("ignored_start_valid", 32'(valid_cnt_a - v0), 32'd1);
    end
  endtask

  task automatic frameB(input logic [F2-1:0] w0, input logic [F2-1:0] w1);
    int e0, v0;
    tx0_b = w0;
    tx1_b = w1;
    v0 = valid_cnt_b;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    e0 = cyc;
    waitUntil(e0 + T2_VALID - 1);
    checkOutput("b_valid_early", 32'(valid_b), 32'd0);
    waitUntil(e0 + T2_VALID);
    checkOutput("b_valid_pulse", 32'(valid_b), 32'd1);
    checkOutput("b_dout0", 32'(dout0_b), 32'(w0));
    checkOutput("b_dout1", 32'(dout1_b), 32'(w1));
    waitUntil(e0 + T2_IDLE);
    checkOutput("b_busy_done", 32'(busy_b), 32'd0);
    checkOutput("b_valid_count", 32'(valid_cnt_b - v0), 32'd1);
  endtask

  initial begin
    int e0, v0;
    logic [F-1:0] r0w, r1w;
    rst = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_cs", 32'(cs_n_a), 32'd1);
    checkOutput("rst_sclk", 32'(sclk_a), 32'd1);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_valid", 32'(valid_a), 32'd0);
    checkOutput("rst_dout0", 32'(dout0_a), 32'd0);
    checkOutput("rst_dout1", 32'(dout1_a), 32'd0);
    checkOutput("rst_b_busy", 32'(busy_b), 32'd0);
    start_a = 1'b0;
    start_b = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_idle", 32'(busy_a), 32'd0);

    $display("[TB] basic frame");
    applyStimulus(16'h0A5C, 16'h03F1, 1'b0);

    $display("[TB] reset mid-frame");
    tx0_a = 16'(F'($urandom));
    tx1_a = 16'(F'($urandom));
    v0 = valid_cnt_a;
    pulseStartA(e0);
    waitUntil(e0 + 29);
    rst = 1'b0;
    waitUntil(e0 + 30);
    rst = 1'b1;
    checkOutput("mid_rst_cs", 32'(cs_n_a), 32'd1);
    checkOutput("mid_rst_sclk", 32'(sclk_a), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy_a), 32'd0);
    checkOutput("mid_rst_dout0", 32'(dout0_a), 32'd0);
    checkOutput("mid_rst_dout1", 32'(dout1_a), 32'd0);
    waitUntil(e0 + 100);
    checkOutput("mid_rst_no_valid", 32'(valid_cnt_a - v0), 32'd0);

    $display("[TB] leading bits nonzero, ignored starts");
    applyStimulus(16'hF123, 16'hF123, 1'b1);

    $display("[TB] random frames");
    for (int i = 0; i < 4; i++) begin
      r0w = F'($urandom);
      r1w = F'($urandom);
      applyStimulus(r0w, r1w, 1'b0);
    end

    $display("[TB] start held high");
    tx0_a = 16'h0BEE;
    tx1_a = 16'h0123;
    v0 = valid_cnt_a;
    @(negedge clk);
    start_a = 1'b1;
    e0 = cyc + 1;
    waitUntil(e0 + T_IDLE);
    checkOutput("held_idle_gap", 32'(busy_a), 32'd0);
    waitUntil(e0 + T_IDLE + 1);
    start_a = 1'b0;
    checkOutput("held_restart", 32'(busy_a), 32'd1);
    waitUntil(e0 + 2 * (T_IDLE + 1) + 3);
    checkOutput("held_valid_count", 32'(valid_cnt_a - v0), 32'd2);
    checkOutput("held_spacing", 32'(last_valid_a - prev_valid_a), 32'(T_IDLE + 1));
    checkOutput("held_cs_gap", 32'(last_run_a >= Q), 32'd1);
    checkOutput("held_dout0", 32'(dout0_a), 32'h0BEE);

    $display("[TB] CLK_DIV=1 instance");
    frameB(12'hFFF, 12'h000);
    frameB(12'h000, 12'hFFF);
    frameB(12'(F2'($urandom)), 12'hA53);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
